sync_updown_counter: RTL and testbench
======================================

// Module: sync_updown_counter
//
// PURPOSE
// Fully synchronous, parametrised up/down counter. It succeeds the ripple T-flip-flop counter.
// Every bit switches on the same clk edge, so there is no ripple skew.
// Adds programmable modulus, parallel load, count enable, an enable prescaler,
// wrap-or-saturate mode, and terminal-count/wrap flags.
// Used as the general event/timebase counter in the lab designs.
//
// PARAMETERS
// WIDTH     4   counter width in bits; WIDTH >= 1
// MODULUS   16  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PRESCALE  1   enabled cycles per count step; PRESCALE >= 1 (1 = step every enabled cycle)
// SATURATE  0   0 = wrap at range ends; 1 = hold at range ends
//
// PORTS
// clk       in   1      clock; all state changes on posedge clk
// reset     in   1      synchronous, active-high reset
// en        in   1      count enable; advances the prescaler
// up        in   1      direction: 1 = increment, 0 = decrement; sampled on step cycles only
// load      in   1      synchronous parallel load
// load_val  in   WIDTH  value to load
// q         out  WIDTH  current count (registered)
// tc        out  1      terminal count (combinational from q and up)
// wrap      out  1      one-cycle registered pulse after a wrap step
//
// BEHAVIOUR
// - Priority at each posedge clk: reset > load > count. Synchronous reset is the only reset; there is no async path.
// - Reset: q=0, prescaler=0, wrap=0. tc then follows its equation (up=1 -> tc=0; up=0 -> tc=1).
// - Load:
//   - q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamp).
//   - Prescaler cleared. wrap=0. No count step occurs in a load cycle, even with en=1.
// - Prescaler (internal, ceil(log2(PRESCALE)) bits, minimum 1 bit):
//   - en=1: a cycle is a "step cycle" when the prescaler equals PRESCALE-1. On a step cycle the prescaler clears; otherwise it increments.
//   - en=0: prescaler and q hold. wrap=0.
//   - PRESCALE=1: every enabled cycle is a step cycle.
// - Step, up=1:
//   - q < MODULUS-1: q+1.
//   - q == MODULUS-1, SATURATE=0: q=0, wrap=1 next cycle.
//   - q == MODULUS-1, SATURATE=1: q holds, wrap=0.
// - Step, up=0:
//   - q > 0: q-1.
//   - q == 0, SATURATE=0: q=MODULUS-1, wrap=1.
//   - q == 0, SATURATE=1: q holds, wrap=0.
// - Latency: q changes on the same edge that ends the step cycle (1 clk). wrap is high for exactly one cycle after that edge.
// - wrap is 0 on every non-wrapping cycle.
// - tc = (up && q == MODULUS-1) || (!up && q == 0). Purely combinational; no extra latency.
// - Direction change mid-prescale does not reset the prescaler. The new direction applies at the next step cycle.
// - Arithmetic is modulo MODULUS, not 2**WIDTH. q never holds a value >= MODULUS.
// - Reset asserted mid-count, simultaneous with load/en, wins. Counting resumes the cycle after reset deasserts.
//
// TESTING (WIDTH=4, MODULUS=10, PRESCALE=1, SATURATE=0 unless noted)
// 1. Wrap up: reset, then en=1 up=1 for 12 cycles -> q = 1..9,0,1,2; wrap=1 only in the cycle after q 9->0; tc=1 while q=9.
// 2. Wrap down: reset, en=1 up=0 -> q = 9,8,7; wrap pulses once after 0->9; tc=1 while q=0.
// 3. Load: q=4, load=1 load_val=7 en=1 -> q=7 next edge, no step; load_val=12 -> q=9 (clamped).
// 4. Saturate (SATURATE=1): count up from 7 for 5 cycles -> q = 8,9,9,9,9; wrap never 1; tc stays 1.
// 5. Prescale (PRESCALE=3): en=1 up=1 -> q steps every 3rd cycle. en=0 for 2 cycles mid-period -> step delayed exactly 2 cycles.
// 6. Reset priority: mid-count at q=5 assert reset with load=1 load_val=3 en=1 -> q=0, wrap=0. Next enabled cycle -> q=1.

Source files
------------

// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with programmable modulus, parallel load,
// count enable, enable prescaler, wrap-or-saturate mode and terminal-count/wrap flags.
module sync_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PresLast = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             step;

  // Next-state: load beats counting; a step happens only on the prescaler's last phase.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
      presc_d = '0;
    end else if (en) begin
      step = (presc_q == PresLast);
      if (step) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (step) begin
        if (up) begin
          if (count_q == MaxVal) begin
            if (!SATURATE) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            if (!SATURATE) begin
              count_d = MaxVal;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count follows the current direction with no added latency.
  always_comb begin
    q    = count_q;
    wrap = wrap_q;
    tc   = up ? (count_q == MaxVal) : (count_q == '0);
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream and
// are compared every cycle against an integer reference model.
module tb_sync_updown_counter;

  localparam int NCFG = 3;
  // Config 0: wrap, PRESCALE 1; config 1: saturate; config 2: PRESCALE 3.
  localparam int MODS [NCFG] = '{10, 10, 10};
  localparam int PRES [NCFG] = '{1, 1, 3};
  localparam int SATS [NCFG] = '{0, 1, 0};

  logic       clk;
  logic       reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q_a    [NCFG];
  logic       tc_a   [NCFG];
  logic       wrap_a [NCFG];

  int n_checks;
  int n_fail;

  // Reference model state.
  int mq [NCFG];
  int mp [NCFG];
  int mw [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0])
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1])
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1'b0)) u_pre (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the applied inputs.
  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      if (reset) begin
        mq[k] = 0; mp[k] = 0; mw[k] = 0;
      end else if (load) begin
        mq[k] = (int'(load_val) >= MODS[k]) ? MODS[k] - 1 : int'(load_val);
        mp[k] = 0; mw[k] = 0;
      end else if (en) begin
        int nxt;
        mw[k] = 0;
        mp[k] = (mp[k] + 1) % PRES[k];
        if (mp[k] == 0) begin
          nxt = up ? mq[k] + 1 : mq[k] - 1;
          if (nxt < 0 || nxt >= MODS[k]) begin
            if (SATS[k] == 0) begin
              mq[k] = (nxt + MODS[k]) % MODS[k];
              mw[k] = 1;
            end
          end else begin
            mq[k] = nxt;
          end
        end
      end else begin
        mw[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NCFG; k++) begin
      int etc;
      etc = up ? int'(mq[k] == MODS[k] - 1) : int'(mq[k] == 0);
      check($sformatf("cfg%0d_q", k), int'(q_a[k]), mq[k]);
      check($sformatf("cfg%0d_wrap", k), int'(wrap_a[k]), mw[k]);
      check($sformatf("cfg%0d_tc", k), int'(tc_a[k]), etc);
    end
  endtask

  // Apply inputs, clock once, then compare 1 time unit after the edge.
  task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                     input logic [3:0] lv);
    reset = r; load = l; en = e; up = u; load_val = lv;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < NCFG; k++) begin
      mq[k] = 0; mp[k] = 0; mw[k] = 0;
    end
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 4'd0;
    @(negedge clk);

    // Reset state, both directions of tc.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    check("rst_tc_up", int'(tc_a[0]), 0);
    up = 1'b0; #1;
    check("rst_tc_dn", int'(tc_a[0]), 1);

    // Wrap up: q = 1..9,0,1,2.
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check("up_q", int'(q_a[0]), i % 10);
      check("up_wrap", int'(wrap_a[0]), int'(i == 10));
      check("up_tc", int'(tc_a[0]), int'(i == 9));
    end

    // Wrap down from reset: 9,8,7.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check("dn_q", int'(q_a[0]), 9 - i);
      check("dn_wrap", int'(wrap_a[0]), int'(i == 0));
    end

    // Load without step, then clamped load.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    check("load_q", int'(q_a[0]), 7);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    check("load_clamp", int'(q_a[0]), 9);

    // Saturate from 7: 8,9,9,9,9.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check("sat_q", int'(q_a[1]), (i == 0) ? 8 : 9);
      check("sat_wrap", int'(wrap_a[1]), 0);
    end
    check("sat_tc", int'(tc_a[1]), 1);

    // Prescale 3: step on every 3rd enabled cycle; a 2-cycle pause delays it by 2.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check("pre_q", int'(q_a[2]), i / 3);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check("pre_hold", int'(q_a[2]), 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check("pre_delayed", int'(q_a[2]), 3);

    // Reset beats load/en at q=5.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    check("rstpri_q", int'(q_a[0]), 0);
    check("rstpri_wrap", int'(wrap_a[0]), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check("rstpri_resume", int'(q_a[0]), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
